// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: word-aligned req/ack memory access with
// sub-word load extraction, read-modify-write sub-word stores and misalign detection.
module load_store_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              op_valid,
   input  logic [3:0]        op_code,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rd_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t            state, state_nxt;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rd_q;
   logic              err_q;

   logic              in_mis;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic [31:0]       load_val;
   logic [31:0]       merged;

   always_comb begin
      in_mis = 1'b0;
      case (op_code[1:0])
         2'b01:   in_mis = addr[0];
         2'b10:   in_mis = (addr[1:0] != 2'b00);
         2'b11:   in_mis = 1'b1;
         default: in_mis = 1'b0;
      endcase
   end

   // wdata_q doubles as the write word: raw data for sw, merged word for sb/sh.
   always_comb begin
      lane_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
      lane_h   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
      load_val = mem_rdata;
      merged   = mem_rdata;
      case (op_q[1:0])
         2'b00: begin
            load_val = op_q[2] ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         end
         2'b01: begin
            load_val = op_q[2] ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         end
         default: begin
            load_val = mem_rdata;
            merged   = mem_rdata;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            busy = op_valid;
            if (op_valid) begin
               if (in_mis)                           state_nxt = DONE;
               else if (op_code[3] && op_code[1])    state_nxt = WR;
               else                                  state_nxt = RD;
            end
         end
         RD: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            if (mem_ack) state_nxt = op_q[3] ? WR : DONE;
         end
         WR: begin
            busy    = 1'b1;
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            err       = err_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (op_valid) begin
                  op_q    <= op_code;
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  rd_q    <= '0;
                  err_q   <= in_mis;
               end
            end
            RD: begin
               if (mem_ack) begin
                  if (op_q[3]) wdata_q <= merged;
                  else         rd_q    <= load_val;
               end
            end
            default: ;
         endcase
      end
   end

   assign rd_data   = rd_q;
   assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata = wdata_q;

endmodule
